// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle for the GRF writeback arbiter: W-stage request, aux issue/result,
// decode scoreboard queries and the shared GRF write port.
interface grf_wb_arbiter_if;
  // W stage
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic [31:0] pipe_pc;
  logic        pipe_stall;
  // Aux issue (reservation) and result
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [31:0] aux_pc;
  // Decode hazard queries
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_busy1;
  logic        q_busy2;
  // GRF write port
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_wpc;

  // Arbiter side
  modport slave (
    input  pipe_we, pipe_addr, pipe_data, pipe_pc,
    input  iss_valid, iss_addr,
    input  aux_valid, aux_addr, aux_data, aux_pc,
    input  q_addr1, q_addr2,
    output pipe_stall, aux_ready, q_busy1, q_busy2,
    output grf_we, grf_a3, grf_wd, grf_wpc
  );

  // Environment side (pipeline, aux unit, GRF)
  modport master (
    output pipe_we, pipe_addr, pipe_data, pipe_pc,
    output iss_valid, iss_addr,
    output aux_valid, aux_addr, aux_data, aux_pc,
    output q_addr1, q_addr2,
    input  pipe_stall, aux_ready, q_busy1, q_busy2,
    input  grf_we, grf_a3, grf_wd, grf_wpc
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: the W stage has priority, aux results wait in a FIFO
// and win after STARVE_LIMIT blocked cycles. A 32-bit scoreboard tracks
// registers reserved by in-flight aux ops.
// Optional macro GRF_WB_TRACE_EN: prints a trace line for every GRF write.
module grf_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  grf_wb_arbiter_if.slave   bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  logic [4:0]    addr_q [FIFO_DEPTH];
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   pc_q   [FIFO_DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   sb_q, sb_d;

  logic          empty, full, aux_ready_int, push, pop, pipe_live, grant_aux;
  logic [4:0]    head_addr;
  logic          head_dup;

  // Handshake and grant decisions, all from registered FIFO state
  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == FullCount);
    aux_ready_int = !full && !reset;
    push          = bus.aux_valid && aux_ready_int;
    pipe_live     = bus.pipe_we && (bus.pipe_addr != 5'd0);
    grant_aux     = !reset && !empty && (!pipe_live || (starve_q == StarveMax));
    pop           = grant_aux;
    head_addr     = addr_q[rd_ptr_q];
  end

  // Does any other live entry (or the one arriving now) still target the head's register?
  always_comb begin
    logic [AW-1:0] offs;
    logic [AW-1:0] slot;
    head_dup = 1'b0;
    offs     = '0;
    slot     = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      slot = AW'(i);
      offs = slot - rd_ptr_q;
      if ((offs != '0) && (CW'(offs) < count_q) && (addr_q[slot] == head_addr)) begin
        head_dup = 1'b1;
      end
    end
    if (push && (bus.aux_addr == head_addr)) begin
      head_dup = 1'b1;
    end
  end

  // Write-port mux and external outputs; everything quiet during reset
  always_comb begin
    bus.aux_ready  = aux_ready_int;
    bus.pipe_stall = pipe_live && grant_aux;
    bus.grf_we     = 1'b0;
    bus.grf_a3     = 5'd0;
    bus.grf_wd     = 32'd0;
    bus.grf_wpc    = 32'd0;
    if (grant_aux) begin
      bus.grf_we  = 1'b1;
      bus.grf_a3  = head_addr;
      bus.grf_wd  = data_q[rd_ptr_q];
      bus.grf_wpc = pc_q[rd_ptr_q];
    end else if (pipe_live && !reset) begin
      bus.grf_we  = 1'b1;
      bus.grf_a3  = bus.pipe_addr;
      bus.grf_wd  = bus.pipe_data;
      bus.grf_wpc = bus.pipe_pc;
    end
    bus.q_busy1 = !reset && sb_q[bus.q_addr1];
    bus.q_busy2 = !reset && sb_q[bus.q_addr2];
  end

  // Next-state for pointers, occupancy, starvation counter and scoreboard
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + SW'(1);
    end

    sb_d = sb_q;
    if (pop && !head_dup) begin
      sb_d[head_addr] = 1'b0;
    end
    // A new reservation overrides a same-cycle release
    if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
      sb_d[bus.iss_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      sb_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      sb_q     <= sb_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.aux_addr;
      data_q[wr_ptr_q] <= bus.aux_data;
      pc_q[wr_ptr_q]   <= bus.aux_pc;
    end
  end

`ifdef GRF_WB_TRACE_EN
  // Simulation trace of every architectural GRF write
  always @(posedge clk) begin
    if (bus.grf_we && (bus.grf_a3 != 5'd0) && !reset) begin
      if (grant_aux) begin
        $display("AUX %d@%h: $%d <= %h", $time, bus.grf_wpc, bus.grf_a3, bus.grf_wd);
      end else begin
        $display("%d@%h: $%d <= %h", $time, bus.grf_wpc, bus.grf_a3, bus.grf_wd);
      end
    end
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: expected GRF writes are queued by the
// stimulus and matched by a negedge monitor; side outputs are checked inline.
module tb_grf_wb_arbiter;

  logic clk;
  logic reset;
  grf_wb_arbiter_if bus();

  grf_wb_arbiter #(
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
    logic        stall;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                           input logic stall);
    wr_t e;
    e.a = a; e.d = d; e.pc = pc; e.stall = stall;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge; inputs are then driven
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_we   = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0; bus.pipe_pc = '0;
    bus.iss_valid = 1'b0; bus.iss_addr  = '0;
    bus.aux_valid = 1'b0; bus.aux_addr  = '0; bus.aux_data  = '0; bus.aux_pc  = '0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.pipe_we = 1'b1; bus.pipe_addr = a; bus.pipe_data = d; bus.pipe_pc = pc;
  endtask

  task automatic aux(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.aux_valid = 1'b1; bus.aux_addr = a; bus.aux_data = d; bus.aux_pc = pc;
  endtask

  // Scoreboard monitor: every GRF write must match the oldest expectation
  always @(negedge clk) begin
    wr_t got;
    wr_t e;
    if (!reset) begin
      if (bus.grf_we) begin
        got.a = bus.grf_a3; got.d = bus.grf_wd; got.pc = bus.grf_wpc; got.stall = bus.pipe_stall;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got a3=%0d wd=%0h wpc=%0h stall=%0b, none expected",
                   got.a, got.d, got.pc, got.stall);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL grf_write: got a3=%0d wd=%0h wpc=%0h stall=%0b expected a3=%0d wd=%0h wpc=%0h stall=%0b",
                     got.a, got.d, got.pc, got.stall, e.a, e.d, e.pc, e.stall);
          end
        end
      end else if (bus.pipe_stall) begin
        checks++;
        failures++;
        $display("FAIL stall_no_write: got pipe_stall=1 expected 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.q_addr1 = '0;
    bus.q_addr2 = '0;
    reset = 1'b1;

    // Reset: outputs held quiet even with requests present
    step();
    pipe(5'd7, 32'h77, 32'h70);
    aux(5'd7, 32'h88, 32'h80);
    #2;
    check("rst_grf_we", bus.grf_we, 0);
    check("rst_pipe_stall", bus.pipe_stall, 0);
    check("rst_aux_ready", bus.aux_ready, 0);
    check("rst_q_busy1", bus.q_busy1, 0);
    step();
    reset = 1'b0;
    idle();
    #2;
    check("post_rst_ready", bus.aux_ready, 1);
    check("post_rst_we", bus.grf_we, 0);

    // Pipe-only write goes straight through
    step();
    pipe(5'd5, 32'h1234, 32'h3000);
    expect_wr(5'd5, 32'h1234, 32'h3000, 1'b0);
    #2;
    check("t1_stall", bus.pipe_stall, 0);
    check("t1_we", bus.grf_we, 1);

    // Issue $8, push its result, watch busy rise and fall
    step();
    idle();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd8; bus.q_addr1 = 5'd8;
    #2;
    check("t2_busy_issue", bus.q_busy1, 0);
    step();
    idle();
    aux(5'd8, 32'hBEEF, 32'h4000);
    #2;
    check("t2_busy_after_issue", bus.q_busy1, 1);
    check("t2_ready", bus.aux_ready, 1);
    step();
    idle();
    expect_wr(5'd8, 32'hBEEF, 32'h4000, 1'b0);
    #2;
    check("t2_busy_during_write", bus.q_busy1, 1);
    step();
    #2;
    check("t2_busy_after_pop", bus.q_busy1, 0);
    check("t2_no_write", bus.grf_we, 0);

    // Starvation: one entry blocked 8 cycles, then one stalled pipe cycle
    for (int k = 0; k <= 10; k++) begin
      step();
      idle();
      if (k == 0) aux(5'd10, 32'hAAAA, 32'h5000);
      if (k == 10) pipe(5'd6, 32'h109, 32'h5109);
      else         pipe(5'd6, 32'h100 + k, 32'h5100 + k);
      if (k == 9) expect_wr(5'd10, 32'hAAAA, 32'h5000, 1'b1);
      else if (k == 10) expect_wr(5'd6, 32'h109, 32'h5109, 1'b0);
      else expect_wr(5'd6, 32'h100 + k, 32'h5100 + k, 1'b0);
      #2;
      if (k == 8) check("t3_stall_k8", bus.pipe_stall, 0);
      if (k == 9) check("t3_stall_k9", bus.pipe_stall, 1);
      if (k == 10) check("t3_stall_k10", bus.pipe_stall, 0);
    end

    // Fill the FIFO under a saturated pipe; 5th offer refused; in-order drain
    for (int k = 0; k <= 13; k++) begin
      step();
      idle();
      if (k <= 4) aux(5'd11 + 5'(k), 32'hC00 + k, 32'h7000 + 4 * k);
      if (k == 10) pipe(5'd3, 32'h209, 32'h6009);
      else if (k <= 10) pipe(5'd3, 32'h200 + k, 32'h6000 + k);
      if (k <= 8) expect_wr(5'd3, 32'h200 + k, 32'h6000 + k, 1'b0);
      else if (k == 9) expect_wr(5'd11, 32'hC00, 32'h7000, 1'b1);
      else if (k == 10) expect_wr(5'd3, 32'h209, 32'h6009, 1'b0);
      else expect_wr(5'd11 + 5'(k - 10), 32'hC00 + (k - 10), 32'h7000 + 4 * (k - 10), 1'b0);
      #2;
      if (k == 3) check("t4_ready_k3", bus.aux_ready, 1);
      if (k == 4) check("t4_ready_full", bus.aux_ready, 0);
      if (k == 10) check("t4_ready_after_pop", bus.aux_ready, 1);
    end

    // $0 pipe write does not hold the slot
    step();
    idle();
    aux(5'd12, 32'hD00D, 32'h7100);
    step();
    idle();
    pipe(5'd0, 32'hFFFF, 32'h7777);
    expect_wr(5'd12, 32'hD00D, 32'h7100, 1'b0);
    #2;
    check("t5_stall", bus.pipe_stall, 0);
    check("t5_a3", bus.grf_a3, 12);
    step();
    idle();
    #2;
    check("t5_idle_we", bus.grf_we, 0);

    // Reset mid-operation drops queued entries and reservations
    bus.q_addr1 = 5'd9;
    for (int k = 0; k <= 2; k++) begin
      step();
      idle();
      if (k == 0) begin bus.iss_valid = 1'b1; bus.iss_addr = 5'd9; end
      pipe(5'd4, 32'h300 + k, 32'h9000 + k);
      aux(5'd20 + 5'(k), 32'h400 + k, 32'hA000 + k);
      expect_wr(5'd4, 32'h300 + k, 32'h9000 + k, 1'b0);
      #2;
      if (k == 1) check("t6_busy_before", bus.q_busy1, 1);
    end
    step();
    reset = 1'b1;
    #2;
    check("t6_rst_we", bus.grf_we, 0);
    check("t6_rst_stall", bus.pipe_stall, 0);
    check("t6_rst_ready", bus.aux_ready, 0);
    step();
    reset = 1'b0;
    idle();
    #2;
    check("t6_ready", bus.aux_ready, 1);
    check("t6_busy9", bus.q_busy1, 0);
    check("t6_we", bus.grf_we, 0);
    step();
    #2;
    check("t6_we2", bus.grf_we, 0);

    // Two queued results to the same register: busy holds until the last pops
    step();
    idle();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd13; bus.q_addr2 = 5'd13;
    step();
    idle();
    pipe(5'd2, 32'h500, 32'hB000);
    aux(5'd13, 32'h1, 32'h8000);
    expect_wr(5'd2, 32'h500, 32'hB000, 1'b0);
    #2;
    check("t7_busy_issue", bus.q_busy2, 1);
    step();
    idle();
    pipe(5'd2, 32'h501, 32'hB004);
    aux(5'd13, 32'h2, 32'h8004);
    expect_wr(5'd2, 32'h501, 32'hB004, 1'b0);
    step();
    idle();
    expect_wr(5'd13, 32'h1, 32'h8000, 1'b0);
    step();
    expect_wr(5'd13, 32'h2, 32'h8004, 1'b0);
    #2;
    check("t7_busy_dup", bus.q_busy2, 1);
    step();
    #2;
    check("t7_busy_clear", bus.q_busy2, 0);

    step();
    step();
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
